imem_line_fetcher: RTL
======================

Name: imem_line_fetcher

Overview:
- Requester-side master for the instruction RAM.
- Accepts a line-fill request from the instruction cache and reads LINE_WORDS consecutive words through the RAM's synchronous read port, which has 1-cycle latency.
- Assembles the words into one cache line and returns it over a valid/ready handshake.
- Sits between the I-cache miss logic and the instruction RAM; never writes the RAM.

Parameters:
- LINE_WORDS_LOG, 3, log2 of words per line (default 8 words).
- ADDR_W, 12, word-address width, matching the RAM addra.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  line-fill request valid.
- req_ready  out  1  fetcher can accept a request.
- req_addr  in  ADDR_W  word address of the miss; low LINE_WORDS_LOG bits ignored.
- mem_addr  out  ADDR_W  RAM read address (addra).
- mem_wea  out  4  RAM byte write enables; constant 4'b0000.
- mem_dina  out  32  RAM write data; constant 0.
- mem_douta  in  32  RAM read data, registered by the RAM, valid 1 cycle after the address.
- line_valid  out  1  assembled line available.
- line_ready  in  1  consumer accepts the line.
- line_addr  out  ADDR_W  line base address (low LINE_WORDS_LOG bits zero).
- line_data  out  32*LINE_WORDS  word k at bits [32k+31:32k].
- fill_count  out  16  completed fills; wraps 16'hFFFF -> 0.

Behaviour:
- States: IDLE, FETCH, DONE.
- Reset (async, any state):
  - state=IDLE; issue_cnt=0, cap_cnt=0, rd_pending=0.
  - Line buffer all 0, line_addr=0, fill_count=0.
  - Outputs: req_ready=1, line_valid=0, mem_addr=0.
- IDLE:
  - req_ready=1, mem_addr=0.
  - On req_valid=1 at an edge (edge E0), latch base = req_addr with low LINE_WORDS_LOG bits cleared, then go to FETCH.
- FETCH issue side:
  - req_ready=0.
  - mem_addr = base + issue_cnt while issue_cnt < LINE_WORDS; otherwise mem_addr = base + LINE_WORDS-1 (harmless re-read).
  - issue_cnt increments each edge, saturating at LINE_WORDS.
  - rd_pending is registered: it is 1 on the edge after each issued address.
- FETCH capture side:
  - On each edge with rd_pending=1, write mem_douta into word cap_cnt and increment cap_cnt.
  - Word k is captured at edge E(k+2).
- FETCH exit:
  - When the last word (cap_cnt=LINE_WORDS-1) is captured, go to DONE and increment fill_count on that same edge.
  - Default timing: line_valid rises after edge E9, i.e. LINE_WORDS+1 edges after acceptance.
- DONE:
  - line_valid=1, req_ready=0.
  - line_data and line_addr held stable while line_ready=0.
  - On line_valid & line_ready at an edge: go to IDLE, clear counters, keep buffer contents.
  - A new request cannot be accepted on that same edge; req_ready is 1 only in IDLE.
- Address arithmetic:
  - base is line-aligned, so base+issue_cnt never carries out of the line; no wrap handling needed.
  - Top line (base = 2^ADDR_W - LINE_WORDS) is fetched normally.
- Concurrency: req_valid is ignored outside IDLE; no queuing, one outstanding fill at most.
- Reset mid-FETCH:
  - Fill is abandoned and line_valid never asserts for it.
  - fill_count is not incremented.
  - The RAM's own reset zeroes douta, so no stale capture occurs after reset release.
- mem_addr, req_ready and line_valid are decoded only from registered state (no combinational path from inputs).

Test Plan:
- Basic fill:
  - Stimulus: RAM word i = 32'hA000_0000+i; req_addr=12'h013 for one cycle.
  - Response: mem_addr sequence 0x010..0x017 on consecutive cycles; line_valid rises 9 edges after acceptance; line_addr=0x010; word k = 32'hA000_0010+k; fill_count=1.
- Back-pressure:
  - Stimulus: hold line_ready=0 for 20 cycles after line_valid.
  - Response: line_data and line_valid stable; req_ready=0; a req_valid pulse in this window is ignored. Release -> IDLE next edge, req_ready=1.
- Back-to-back:
  - Stimulus: req_valid held high with addresses 0x000 then 0x3F8; line_ready tied 1.
  - Response: two fills, second accepted the cycle after first handshake; second line = words 0x3F8..0x3FF; fill_count=2.
- Reset mid-fill:
  - Stimulus: assert rst asynchronously after 4 words captured.
  - Response: immediately req_ready=1, line_valid=0, mem_addr=0, fill_count unchanged at 0. A following fill of 0x020 returns correct data.
- Write-port safety:
  - Stimulus: across all above.
  - Response: mem_wea=0 and mem_dina=0 every cycle; RAM contents unchanged after the test.
- Counter wrap:
  - Stimulus: force fill_count=16'hFFFF, complete one fill.
  - Response: fill_count=0.

Source files
------------

// File: rtl/imem_line_fetcher.sv
// Instruction-RAM line fetcher: reads LINE_WORDS consecutive words through a
// 1-cycle-latency synchronous read port and returns them as one cache line.
module imem_line_fetcher #(
    parameter int unsigned LINE_WORDS_LOG = 3,
    parameter int unsigned ADDR_W         = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_W-1:0]                    req_addr,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [3:0]                           mem_wea,
    output logic [31:0]                          mem_dina,
    input  logic [31:0]                          mem_douta,
    output logic                                 line_valid,
    input  logic                                 line_ready,
    output logic [ADDR_W-1:0]                    line_addr,
    output logic [32*(1<<LINE_WORDS_LOG)-1:0]    line_data,
    output logic [15:0]                          fill_count
);

    localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG;
    localparam logic [LINE_WORDS_LOG:0]   ISSUE_MAX = (LINE_WORDS_LOG+1)'(LINE_WORDS);
    localparam logic [LINE_WORDS_LOG-1:0] LAST_CAP  = LINE_WORDS_LOG'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]         LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [LINE_WORDS_LOG:0]   issue_cnt;
    logic [LINE_WORDS_LOG-1:0] cap_cnt;
    logic                      rd_pending;
    logic                      issuing;
    logic                      last_capture;

    assign issuing      = (issue_cnt < ISSUE_MAX);
    assign last_capture = rd_pending && (cap_cnt == LAST_CAP);

    assign mem_wea  = 4'b0000;
    assign mem_dina = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)    state_d = FETCH;
            FETCH:   if (last_capture) state_d = DONE;
            DONE:    if (line_ready)   state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Once every word is issued the port keeps re-reading the last word; harmless.
    always_comb begin
        req_ready  = (state_q == IDLE);
        line_valid = (state_q == DONE);
        mem_addr   = '0;
        if (state_q == FETCH) begin
            if (issuing) begin
                mem_addr = line_addr + ADDR_W'(issue_cnt);
            end else begin
                mem_addr = line_addr + ADDR_W'(LINE_WORDS - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            rd_pending <= 1'b0;
            line_addr  <= '0;
            line_data  <= '0;
            fill_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        line_addr  <= req_addr & LINE_MASK;
                        issue_cnt  <= '0;
                        cap_cnt    <= '0;
                        rd_pending <= 1'b0;
                    end
                end
                FETCH: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    // Read data trails its address by one edge.
                    rd_pending <= issuing;
                    if (rd_pending) begin
                        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                            if (cap_cnt == LINE_WORDS_LOG'(k)) begin
                                line_data[32*k +: 32] <= mem_douta;
                            end
                        end
                        cap_cnt <= cap_cnt + 1'b1;
                        if (cap_cnt == LAST_CAP) begin
                            fill_count <= fill_count + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (line_ready) begin
                        issue_cnt  <= '0;
                        cap_cnt    <= '0;
                        rd_pending <= 1'b0;
                    end
                end
                default: begin
                    issue_cnt  <= '0;
                    cap_cnt    <= '0;
                    rd_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
